// File: rtl/multi_bank_dual_port_ram_pkg.sv
// Shared types and helpers for the multi-bank simple-dual-port RAM.
package multi_bank_dual_port_ram_pkg;

  typedef enum logic {CLEAR, READY} ram_clear_state_t;

  function automatic int entry_count(input int index_width);
    return 1 << index_width;
  endfunction

endpackage

// File: rtl/multi_bank_dual_port_ram_block_ram_sdp.sv
// One bank column: separate write and read ports, 1-cycle read-first output
// register that holds its value on cycles without a read.
module multi_bank_dual_port_ram_block_ram_sdp
  import multi_bank_dual_port_ram_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int INDEX_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rstN,
  input  logic                   write_en,
  input  logic [INDEX_WIDTH-1:0] write_index,
  input  logic [DATA_WIDTH-1:0]  write_data,
  input  logic                   read_en,
  input  logic [INDEX_WIDTH-1:0] read_index,
  output logic [DATA_WIDTH-1:0]  read_data
);

  localparam int ENTRY_COUNT = entry_count(INDEX_WIDTH);

  logic [DATA_WIDTH-1:0] mem [ENTRY_COUNT];

  always_ff @(posedge clk) begin
    if (write_en) mem[write_index] <= write_data;
  end

  // Output register sync reset maps onto the block RAM's output reset pin.
  always_ff @(posedge clk) begin
    if (!rstN)        read_data <= '0;
    else if (read_en) read_data <= mem[read_index];
  end

endmodule

// File: rtl/multi_bank_dual_port_ram.sv
// Multi-bank simple-dual-port RAM with clear sequencer and 1/2-cycle read latency.
// Define RAM_WRITE_BYPASS_EN to forward same-cycle same-index writes to the read port.
module multi_bank_dual_port_ram
  import multi_bank_dual_port_ram_pkg::*;
#(
  parameter int DATA_WIDTH_PER_BANK = 32,
  parameter int BANK_COUNT          = 4,
  parameter int INDEX_WIDTH         = 8,
  parameter int READ_LATENCY        = 1
) (
  input  logic                                      clk,
  input  logic                                      rstN,
  output logic                                      ready,
  input  logic                                      clearRequest,
  input  logic                                      readEnable,
  input  logic [INDEX_WIDTH-1:0]                    readIndex,
  output logic                                      readValid,
  output logic [BANK_COUNT*DATA_WIDTH_PER_BANK-1:0] readValue,
  input  logic                                      writeEnable,
  input  logic [INDEX_WIDTH-1:0]                    writeIndex,
  input  logic [BANK_COUNT*DATA_WIDTH_PER_BANK-1:0] writeValue,
  input  logic [BANK_COUNT-1:0]                     writeMask
);

  localparam int DW = DATA_WIDTH_PER_BANK;

  generate
    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
      $error("multi_bank_dual_port_ram: READ_LATENCY must be 1 or 2");
    end
  endgenerate

  ram_clear_state_t state, next_state;
  logic [INDEX_WIDTH-1:0] clear_index;
  logic clearing, read_accept, write_accept;
  logic [READ_LATENCY:1] vld_pipe;
  logic [BANK_COUNT-1:0][DW-1:0] write_banks, bank_q, array_q;

  assign write_banks = writeValue;

  // Clear sequencer: state register, next-state logic, outputs.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      state       <= CLEAR;
      clear_index <= '0;
    end else begin
      state <= next_state;
      if (state == CLEAR) clear_index <= clear_index + 1'b1;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      CLEAR:   if (clear_index == '1) next_state = READY;
      READY:   if (clearRequest)      next_state = CLEAR;
      default: next_state = CLEAR;
    endcase
  end

  always_comb begin
    ready    = (state == READY);
    clearing = (state == CLEAR);
  end

  assign read_accept  = readEnable  && ready;
  assign write_accept = writeEnable && ready;

  for (genvar b = 0; b < BANK_COUNT; b++) begin : g_bank
    logic                   we;
    logic [INDEX_WIDTH-1:0] widx;
    logic [DW-1:0]          wdat;

    always_comb begin
      we   = rstN && (clearing || (write_accept && writeMask[b]));
      widx = clearing ? clear_index : writeIndex;
      wdat = clearing ? '0 : write_banks[b];
    end

    multi_bank_dual_port_ram_block_ram_sdp #(
      .DATA_WIDTH (DW),
      .INDEX_WIDTH(INDEX_WIDTH)
    ) u_bank (
      .clk        (clk),
      .rstN       (rstN),
      .write_en   (we),
      .write_index(widx),
      .write_data (wdat),
      .read_en    (read_accept),
      .read_index (readIndex),
      .read_data  (bank_q[b])
    );
  end

`ifdef RAM_WRITE_BYPASS_EN
  logic [BANK_COUNT-1:0]         bypass_hit;
  logic [BANK_COUNT-1:0][DW-1:0] bypass_data;

  // Captured alongside the array read so the mux lines up with bank_q.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      bypass_hit  <= '0;
      bypass_data <= '0;
    end else if (read_accept) begin
      bypass_hit  <= (write_accept && writeIndex == readIndex) ? writeMask : '0;
      bypass_data <= write_banks;
    end
  end

  always_comb begin
    for (int b = 0; b < BANK_COUNT; b++)
      array_q[b] = bypass_hit[b] ? bypass_data[b] : bank_q[b];
  end
`else
  assign array_q = bank_q;
`endif

  always_ff @(posedge clk) begin
    if (!rstN) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[1] <= read_accept;
      for (int s = 2; s <= READ_LATENCY; s++) vld_pipe[s] <= vld_pipe[s-1];
    end
  end

  assign readValid = vld_pipe[READ_LATENCY];

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic [BANK_COUNT-1:0][DW-1:0] out_q;
      always_ff @(posedge clk) begin
        if (!rstN)            out_q <= '0;
        else if (vld_pipe[1]) out_q <= array_q;
      end
      assign readValue = out_q;
    end else begin : g_lat1
      assign readValue = array_q;
    end
  endgenerate

endmodule

// File: tb/tb_multi_bank_dual_port_ram.sv
// Scoreboard bench driving a latency-1 and a latency-2 instance with identical stimulus.
module tb_multi_bank_dual_port_ram;
  localparam int DW = 32, BC = 4, IW = 4, W = DW*BC, N = 1 << IW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstN, clear_request, read_enable, write_enable;
  logic [IW-1:0] read_index, write_index;
  logic [W-1:0]  write_value;
  logic [BC-1:0] write_mask;
  logic [1:0]    ready, valid;
  logic [W-1:0]  value [2];

  multi_bank_dual_port_ram #(.DATA_WIDTH_PER_BANK(DW), .BANK_COUNT(BC), .INDEX_WIDTH(IW), .READ_LATENCY(1)) u_lat1 (
    .clk(clk), .rstN(rstN), .ready(ready[0]), .clearRequest(clear_request),
    .readEnable(read_enable), .readIndex(read_index), .readValid(valid[0]), .readValue(value[0]),
    .writeEnable(write_enable), .writeIndex(write_index), .writeValue(write_value), .writeMask(write_mask));

  multi_bank_dual_port_ram #(.DATA_WIDTH_PER_BANK(DW), .BANK_COUNT(BC), .INDEX_WIDTH(IW), .READ_LATENCY(2)) u_lat2 (
    .clk(clk), .rstN(rstN), .ready(ready[1]), .clearRequest(clear_request),
    .readEnable(read_enable), .readIndex(read_index), .readValid(valid[1]), .readValue(value[1]),
    .writeEnable(write_enable), .writeIndex(write_index), .writeValue(write_value), .writeMask(write_mask));

  typedef struct {
    logic [W-1:0] data;
    int           due;
  } exp_t;

  exp_t         q [2][$];
  int           vectors = 0, miscompares = 0, cyc = 0;
  logic [W-1:0] mem [N];
  logic [W-1:0] last [2];
  logic         m_ready = 1'b0;
  int           m_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model of the clear sequencer, advanced once per active edge.
  task automatic tick();
    @(posedge clk);
    if (!rstN) begin
      m_ready = 1'b0; m_cnt = 0;
      foreach (mem[i]) mem[i] = '0;
    end else if (!m_ready) begin
      if (m_cnt == N-1) begin m_ready = 1'b1; m_cnt = 0; end
      else m_cnt++;
    end else if (clear_request) begin
      m_ready = 1'b0; m_cnt = 0;
      foreach (mem[i]) mem[i] = '0;
    end
    #1;
  endtask

  task automatic do_cycle(input logic rst, input logic clr, input logic re, input logic [IW-1:0] ri,
                          input logic we, input logic [IW-1:0] wi, input logic [W-1:0] wv,
                          input logic [BC-1:0] wm);
    exp_t e;
    logic [W-1:0] d;
    chk("ready_lat1", {{(W-1){1'b0}}, ready[0]}, {{(W-1){1'b0}}, m_ready});
    chk("ready_lat2", {{(W-1){1'b0}}, ready[1]}, {{(W-1){1'b0}}, m_ready});
    rstN = rst; clear_request = clr;
    read_enable = re; read_index = ri;
    write_enable = we; write_index = wi; write_value = wv; write_mask = wm;
    if (rst && m_ready && re) begin
      d = mem[ri];
`ifdef RAM_WRITE_BYPASS_EN
      if (we && wi == ri)
        for (int b = 0; b < BC; b++) if (wm[b]) d[b*DW +: DW] = wv[b*DW +: DW];
`endif
      e.data = d;
      e.due = cyc + 1; q[0].push_back(e);
      e.due = cyc + 2; q[1].push_back(e);
    end
    if (rst && m_ready && we)
      for (int b = 0; b < BC; b++) if (wm[b]) mem[wi][b*DW +: DW] = wv[b*DW +: DW];
    tick();
    clear_request = 1'b0; read_enable = 1'b0; write_enable = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) do_cycle(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, '0, '0);
  endtask

  task automatic rd(input logic [IW-1:0] i);
    do_cycle(1'b1, 1'b0, 1'b1, i, 1'b0, '0, '0, '0);
  endtask

  task automatic wr(input logic [IW-1:0] i, input logic [W-1:0] v, input logic [BC-1:0] m);
    do_cycle(1'b1, 1'b0, 1'b0, '0, 1'b1, i, v, m);
  endtask

  // Scoreboard: pops on readValid, checks data, arrival cycle and output hold.
  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      if (!rstN) begin
        last[d] = '0;
      end else if (valid[d]) begin
        if (q[d].size() == 0) begin
          chk($sformatf("unexpected_valid_lat%0d", d+1), {{(W-1){1'b0}}, valid[d]}, '0);
        end else begin
          e = q[d].pop_front();
          chk($sformatf("read_data_lat%0d", d+1), value[d], e.data);
          chk($sformatf("read_cycle_lat%0d", d+1), W'(cyc), W'(e.due));
          last[d] = value[d];
        end
      end else begin
        chk($sformatf("read_hold_lat%0d", d+1), value[d], last[d]);
        if (q[d].size() > 0 && q[d][0].due <= cyc) begin
          e = q[d].pop_front();
          chk($sformatf("missing_valid_lat%0d", d+1), {{(W-1){1'b0}}, valid[d]}, {{(W-1){1'b0}}, 1'b1});
        end
      end
    end
  end

  initial begin
    logic [W-1:0] v;
    rstN = 1'b0; clear_request = 1'b0; read_enable = 1'b0; write_enable = 1'b0;
    read_index = '0; write_index = '0; write_value = '0; write_mask = '0;
    foreach (mem[i]) mem[i] = '0;
    tick(); tick();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset_ready_lat%0d", d+1), {{(W-1){1'b0}}, ready[d]}, '0);
      chk($sformatf("reset_valid_lat%0d", d+1), {{(W-1){1'b0}}, valid[d]}, '0);
      chk($sformatf("reset_value_lat%0d", d+1), value[d], '0);
    end
    do_cycle(1'b0, 1'b0, 1'b0, '0, 1'b0, '0, '0, '0);

    // Initial clear: 16 cycles not ready; requests in this window are dropped.
    for (int i = 0; i < N; i++) do_cycle(1'b1, 1'b0, 1'b1, IW'(i), 1'b1, 4'd2, '1, 4'hF);
    for (int i = 0; i < N; i++) rd(IW'(i));
    idle(3);

    // Masked write.
    wr(4'd5, {32'hDDDDDDDD, 32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA}, 4'b0101);
    rd(4'd5);
    idle(3);

    // Same-index read/write collision.
    wr(4'd3, {4{32'h11111111}}, 4'hF);
    do_cycle(1'b1, 1'b0, 1'b1, 4'd3, 1'b1, 4'd3, {4{32'h22222222}}, 4'b0011);
    rd(4'd3);
    idle(3);

    // Requested clear: in-flight read keeps pre-clear data, same-cycle write is performed then cleared.
    wr(4'd7, '1, 4'hF);
    rd(4'd7);
    do_cycle(1'b1, 1'b1, 1'b1, 4'd7, 1'b1, 4'd8, {4{32'h55555555}}, 4'hF);
    for (int i = 0; i < N; i++) do_cycle(1'b1, (i == 5), 1'b1, 4'd7, 1'b1, 4'd7, '1, 4'hF);
    rd(4'd7);
    rd(4'd8);
    idle(3);

    // Reset mid-clear at clear index 9 restarts a full clear.
    do_cycle(1'b1, 1'b1, 1'b0, '0, 1'b0, '0, '0, '0);
    idle(9);
    do_cycle(1'b0, 1'b0, 1'b0, '0, 1'b0, '0, '0, '0);
    do_cycle(1'b0, 1'b0, 1'b0, '0, 1'b0, '0, '0, '0);
    idle(N);
    idle(1);

    // Back-to-back reads.
    for (int i = 1; i <= 3; i++) begin
      v = {4{8'(8'hA0 + i), 8'(i), 16'hBEEF}};
      wr(IW'(i), v, 4'hF);
    end
    rd(4'd1); rd(4'd2); rd(4'd3);
    idle(4);

    chk("queue_drained_lat1", W'(q[0].size()), '0);
    chk("queue_drained_lat2", W'(q[1].size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multi_bank_dual_port_ram.md
Name: multi_bank_dual_port_ram

Overview:
- Simple-dual-port (1 read + 1 write per cycle) multi-bank RAM with per-bank write mask.
- Configurable read latency (1 or 2 cycles) with a read-valid pipeline.
- Built-in clear sequencer zeroes every entry after reset or on request, and exposes a ready flag.
- Intended for cache tag/data arrays, BTB and predictor tables.
- Inferred as FPGA block RAM, one primitive column per bank.

Parameters:
- DATA_WIDTH_PER_BANK, 32: bits per bank.
- BANK_COUNT, 4: number of independently write-masked banks.
- INDEX_WIDTH, 8: address width; EntryCount = 1 << INDEX_WIDTH.
- READ_LATENCY, 1: 1 = array output direct; 2 = extra output register. Any other value is an elaboration error.

Ports:
- clk  in  1  clock; all logic on posedge.
- rstN  in  1  synchronous active-low reset.
- ready  out  1  high when array is usable; low while clearing.
- clearRequest  in  1  one-cycle pulse; starts a full clear when ready=1.
- readEnable  in  1  read request.
- readIndex  in  INDEX_WIDTH  read address.
- readValid  out  1  readValue carries data for a request accepted READ_LATENCY cycles earlier.
- readValue  out  BANK_COUNT*DATA_WIDTH_PER_BANK  read data, bank i in slice i.
- writeEnable  in  1  write request.
- writeIndex  in  INDEX_WIDTH  write address.
- writeValue  in  BANK_COUNT*DATA_WIDTH_PER_BANK  write data.
- writeMask  in  BANK_COUNT  per-bank write enable, qualified by writeEnable.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (rstN).
- Reset (rstN=0 at posedge):
  - state <= CLEAR, clearIndex <= 0.
  - ready=0, readValid=0, readValue=0, all read pipeline valid bits 0.
  - The array is not written while rstN=0.
- States: CLEAR, READY.
- CLEAR (rstN=1):
  - Each cycle writes 0 to all banks at clearIndex, then clearIndex <= clearIndex+1.
  - After the write of index EntryCount-1: state <= READY, clearIndex <= 0.
  - Clear takes exactly EntryCount cycles. ready rises on the cycle after the last clear write.
- READY:
  - clearRequest=1 -> CLEAR next cycle. ready drops the same next cycle.
  - A read or write presented in the same cycle as clearRequest is still performed.
- Request gating:
  - A request is accepted only when ready=1 at the sampling edge.
  - writeEnable/readEnable in CLEAR are ignored: no write, no readValid.
  - clearRequest in CLEAR is ignored. rstN low mid-clear restarts from index 0.
- Write: bank i at writeIndex is updated when writeEnable && writeMask[i]. writeMask=0 with writeEnable=1 is a no-op.
- Read timing:
  - READ_LATENCY=1: accepted read at edge N -> readValid=1 and data after edge N+1… i.e. visible in cycle N+1.
  - READ_LATENCY=2: visible in cycle N+2.
  - readValid is a pure delayed copy of accepted readEnable; no back-pressure.
- Read hold: readValue holds its last value when readValid=0 (output register not updated).
- Reads in flight at the start of a clear complete normally with pre-clear data.
- Same-index read and write in one cycle: read-first; old data returned for all banks (default, see optional feature).
- Index arithmetic: clearIndex wraps naturally at INDEX_WIDTH bits. No out-of-range addresses exist.

Optional Feature:
- Macro: RAM_WRITE_BYPASS_EN.
- Defined: on a same-cycle same-index read/write, banks with writeMask[i]=1 return writeValue[i]; other banks return stored data. Implemented with a registered compare and mux on the array output, before the optional latency-2 register.
- Undefined: read-first behaviour as above, with no compare logic.

Decomposition:
- Package RamPkg:
  - RamClearState enum {CLEAR, READY}.
  - Function computing EntryCount from index width.
- Sub-module BlockRamSdp: single bank, separate read/write ports, 1-cycle read-first. Instantiated BANK_COUNT times in a generate loop.
- The top level holds the clear sequencer, bypass logic and latency pipeline.

Test Plan:
- Reset release, INDEX_WIDTH=4 -> ready=0 for exactly 16 cycles, then 1; reads of indices 0..15 all return 0.
- Write idx 5, value 0xDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, mask 4'b0101; then read idx 5 -> 0x00000000_CCCCCCCC_00000000_AAAAAAAA. readValid appears 1 cycle later with READ_LATENCY=1 and 2 cycles later with READ_LATENCY=2.
- Simultaneous read and write to idx 3 (old 0x11.., new 0x22.., mask 4'b0011):
  - Without the macro: returns all-old data.
  - With RAM_WRITE_BYPASS_EN: banks 0-1 return new data, banks 2-3 return old.
- Fill idx 7 with 0xFF.., pulse clearRequest -> ready low for 16 cycles; read idx 7 after ready -> 0. Writes issued during the clear have no effect.
- Assert rstN=0 at clearIndex=9, release -> clear restarts at 0 and lasts a full 16 cycles. readValid=0 throughout.
- Back-to-back reads of idx 1,2,3 on consecutive cycles with READ_LATENCY=2 -> readValid high for 3 consecutive cycles with the matching data in order.
